// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   state_e  : FSM state encoding (IDLE = no grant, BURST = grant held)
//   id_width : width of a binary requester index for n requesters
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // A single requester still needs a 1-bit index so the port exists.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin winner selection (purely combinational).
//   req_i     : request vector
//   last_id_i : index of the previous owner; search starts at last_id_i+1
//   win_oh_o  : one-hot winner (0 when nothing requests)
//   win_id_o  : binary winner (0 when nothing requests)
//   any_req_o : at least one request bit set
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_id_i,
    output logic [N-1:0]   win_oh_o,
    output logic [IDW-1:0] win_id_o,
    output logic           any_req_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // last_id_i is the final (winning) assignment.
    always_comb begin
        win_oh_o = '0;
        win_id_o = '0;
        idx      = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_id_i) + k) % N;
            if (req_i[idx]) begin
                win_oh_o      = '0;
                win_oh_o[idx] = 1'b1;
                win_id_o      = IDW'(idx);
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ write requesters onto a single FIFO write port.
// A grant lasts up to BURST_LEN beats, ends early when the owner drops its
// request, and is always followed by a one-cycle IDLE rearbitration bubble.
//   clk, rst  : clock, asynchronous active-high reset
//   s_valid   : per-requester write request
//   s_data    : requester i data in slice i
//   s_ready   : per-requester beat accepted
//   wr_en     : FIFO write enable
//   wr_data   : FIFO write data (slice of the current owner)
//   wr_full   : FIFO full flag (stalls the burst)
//   grant     : one-hot owner, grant_id : binary owner, busy : grant held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BYTE_WIDTH = 1,
    parameter int BURST_LEN  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              s_valid,
    input  logic [NUM_REQ*BYTE_WIDTH*8-1:0] s_data,
    output logic [NUM_REQ-1:0]              s_ready,
    output logic                            wr_en,
    output logic [BYTE_WIDTH*8-1:0]         wr_data,
    input  logic                            wr_full,
    output logic [NUM_REQ-1:0]              grant,
    output logic [id_width(NUM_REQ)-1:0]    grant_id,
    output logic                            busy
);

    localparam int         DW       = BYTE_WIDTH * 8;
    localparam int         IDW      = id_width(NUM_REQ);
    localparam logic [7:0] CNT_LAST = 8'(BURST_LEN - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDW-1:0]     win_id;
    logic               any_req;

    rr_select #(.N(NUM_REQ), .IDW(IDW)) u_sel (
        .req_i     (s_valid),
        .last_id_i (last_q),
        .win_oh_o  (win_oh),
        .win_id_o  (win_id),
        .any_req_o (any_req)
    );

    // Handshake outputs are gated by rst so nothing is accepted while the
    // reset is still asserted, even in the same cycle it rises.
    always_comb begin
        s_ready = '0;
        if (!rst && state_q == BURST && !wr_full)
            s_ready = grant_q;
        wr_en   = s_valid[gid_q] & s_ready[gid_q];
        wr_data = s_data[int'(gid_q)*DW +: DW];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BURST;
                    grant_d = win_oh;
                    gid_d   = win_id;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (wr_en)
                    cnt_d = cnt_q + 8'd1;
                // Owner dropping its request releases the grant even while
                // the FIFO is full; a full FIFO alone only stalls.
                if (!s_valid[gid_q] || (wr_en && cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    gid_d   = '0;
                    last_d  = gid_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = gid_q;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int BW = 1;
    localparam int BL = 4;
    localparam int DW = BW * 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_valid;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]    s_ready;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            wr_full;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .BYTE_WIDTH(BW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Each requester streams a sequence number; it advances only when the
    // model says the beat was taken, so lost/duplicated beats show on wr_data.
    int           seq [N];
    logic [N-1:0] acc_mask = '0;

    initial for (int i = 0; i < N; i++) seq[i] = 0;

    always @(negedge clk)
        for (int i = 0; i < N; i++)
            if (acc_mask[i]) seq[i] <= seq[i] + 1;

    function automatic logic [DW-1:0] beat(input int id, input int s);
        return DW'((id << 6) | (s & 63));
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_data
        assign s_data[g*DW +: DW] = beat(g, seq[g]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, beats taken, previous owner.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_last  = N - 1;

    initial begin
        logic [N-1:0] e_rdy, e_gnt;
        logic         e_wen;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                m_busy = 0; m_owner = 0; m_cnt = 0; m_last = N - 1;
            end
            e_gnt = m_busy ? N'(1) << m_owner : '0;
            e_rdy = (!rst && m_busy && !wr_full) ? e_gnt : '0;
            e_wen = !rst && m_busy && !wr_full && s_valid[m_owner];
            chk("grant",    grant,    e_gnt);
            chk("grant_id", grant_id, m_busy ? m_owner : 0);
            chk("busy",     busy,     m_busy);
            chk("s_ready",  s_ready,  e_rdy);
            chk("wr_en",    wr_en,    e_wen);
            if (m_busy && !rst) chk("wr_data", wr_data, beat(m_owner, seq[m_owner]));
            acc_mask = e_wen ? N'(1) << m_owner : '0;
            if (!rst) begin
                if (!m_busy) begin
                    for (int k = 1; k <= N; k++)
                        if (!m_busy && s_valid[(m_last + k) % N]) begin
                            m_busy = 1; m_owner = (m_last + k) % N; m_cnt = 0;
                        end
                end else if (!s_valid[m_owner] || (e_wen && m_cnt == BL - 1)) begin
                    m_busy = 0; m_last = m_owner;
                end else if (e_wen) begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [N-1:0] v, input logic f);
        @(negedge clk);
        rst = r; s_valid = v; wr_full = f;
        #3;
    endtask

    initial begin
        int nw, nb, nrise;
        logic pb;
        logic [N-1:0] v;
        logic [N-1:0] fair_g [5];
        fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; s_valid = '0; wr_full = 1'b0;

        // Reset with everyone requesting, then round-robin fairness.
        cyc(1, 4'b1111, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_grant", grant, 0);
        cyc(1, 4'b1111, 0);
        nw = 0;
        for (int s = 0; s < 22; s++) begin
            cyc(0, 4'b1111, 0);
            if (s < 20 && wr_en) nw++;
            if (s % 5 == 1) chk("fair_grant", grant, fair_g[s/5]);
        end
        chk("fair_writes", nw, 16);

        // Early release by requester 2, hand-off to requester 3.
        cyc(1, 4'b1100, 0); cyc(1, 4'b1100, 0);
        cyc(0, 4'b1100, 0);
        chk("early_idle", busy, 0);
        nw = 0;
        for (int s = 0; s < 2; s++) begin
            cyc(0, 4'b1100, 0);
            if (wr_en && grant == 4'b0100) nw++;
        end
        chk("early_beats", nw, 2);
        cyc(0, 4'b1000, 0);
        chk("early_drop_busy", busy, 1);
        chk("early_drop_wen", wr_en, 0);
        cyc(0, 4'b1000, 0);
        chk("early_bubble", busy, 0);
        cyc(0, 4'b1000, 0);
        chk("early_next", grant, 4'b1000);

        // Backpressure for 5 cycles after 2 beats.
        cyc(1, 4'b0001, 0); cyc(1, 4'b0001, 0);
        nw = 0; nb = 0;
        for (int s = 0; s <= 10; s++) begin
            cyc(0, 4'b0001, (s >= 3 && s <= 7));
            if (wr_en) nw++;
            if (busy) nb++;
        end
        chk("bp_writes", nw, 4);
        chk("bp_busy_cycles", nb, 9);

        // Single requester, 12 beats.
        cyc(1, 4'b0010, 0); cyc(1, 4'b0010, 0);
        nw = 0; nb = 0; nrise = 0; pb = 0;
        for (int s = 0; s < 15; s++) begin
            cyc(0, 4'b0010, 0);
            if (wr_en) nw++;
            if (s > 0 && !busy) nb++;
            if (busy && !pb) nrise++;
            pb = busy;
        end
        chk("single_writes", nw, 12);
        chk("single_bubbles", nb, 2);
        chk("single_grants", nrise, 3);

        // Reset pulsed mid-burst.
        cyc(1, 4'b1111, 0); cyc(1, 4'b1111, 0);
        for (int s = 0; s < 3; s++) cyc(0, 4'b1111, 0);
        cyc(1, 4'b1111, 0);
        chk("mrst_grant", grant, 0);
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_ready", s_ready, 0);
        cyc(0, 4'b1111, 0);
        chk("mrst_idle", busy, 0);
        cyc(0, 4'b1111, 0);
        chk("mrst_restart", grant, 4'b0001);

        // Randomized traffic, backpressure and occasional resets.
        v = '0;
        for (int s = 0; s < 3000; s++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) v[i] = ~v[i];
            cyc(($urandom_range(199) == 0), v, ($urandom_range(3) == 0));
        end
        cyc(0, '0, 0);
        cyc(0, '0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
